// File: rtl/mini_src_pkg.sv
// Mini SRC shared definitions: ALU opcodes, IR field
// positions, RAM geometry and the constant-field helper.
package mini_src_pkg;

    localparam int RAM_DEPTH = 512;
    localparam int RAM_AW    = 9;

    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;
    localparam int C2_HI = 20;
    localparam int C2_LO = 19;
    localparam int CK_HI = 18;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    function automatic logic [31:0] sext19(input logic [18:0] c);
        return {{13{c[18]}}, c};
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// Mini SRC ALU, purely combinational.
// a=Y, b=bus, op=opcode, inc_pc forces b+1; result = {high, low}.
module datapath_alu
    import mini_src_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  op,
    input  logic        inc_pc,
    output logic [63:0] result
);

    logic [4:0]         sh;
    logic [5:0]         rsh;
    logic signed [63:0] prod;
    logic [31:0]        quot;
    logic [31:0]        rem;

    assign sh  = b[4:0];
    assign rsh = 6'd32 - {1'b0, sh};

    assign prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

    // Divide by zero yields 0:0 rather than simulator-defined junk.
    always_comb begin
        quot = '0;
        rem  = '0;
        if (b != 32'd0) begin
            quot = $signed(a) / $signed(b);
            rem  = $signed(a) % $signed(b);
        end
    end

    always_comb begin
        result = '0;
        if (inc_pc) begin
            result[31:0] = b + 32'd1;
        end else begin
            case (op)
                OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI:
                    result[31:0] = a + b;
                OP_SUB:          result[31:0] = a - b;
                OP_AND, OP_ANDI: result[31:0] = a & b;
                OP_OR, OP_ORI:   result[31:0] = a | b;
                // A shift of 32 gives 0, so sh=0 rotates to a unchanged.
                OP_ROR: result[31:0] = (a >> sh) | (a << rsh);
                OP_ROL: result[31:0] = (a << sh) | (a >> rsh);
                OP_SHR:  result[31:0] = a >> sh;
                OP_SHRA: result[31:0] = $signed(a) >>> sh;
                OP_SHL:  result[31:0] = a << sh;
                OP_MUL:  result = prod;
                OP_DIV:  result = {rem, quot};
                OP_NEG:  result[31:0] = -b;
                OP_NOT:  result[31:0] = ~b;
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/mini_src_datapath.sv
// Mini SRC 32-bit single-bus datapath driven by one-hot strobes.
// Ports: clk/clr, register in/out enables, bus source selects,
// memory Read/Write, select-and-encode, ALU opcode, input port,
// CON flag, and observation taps of every internal register.
module mini_src_datapath
    import mini_src_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] RX_in_man,
    input  logic [15:0] RX_out_man,
    output logic [15:0] RX_in,
    output logic [15:0] RX_out,
    input  logic        PC_in,
    input  logic        IR_in,
    input  logic        Y_in,
    input  logic        Z_in,
    input  logic        HI_in,
    input  logic        LO_in,
    input  logic        MAR_in,
    input  logic        MDR_in,
    input  logic        OutPort_in,
    input  logic        PC_out,
    input  logic        Zhigh_out,
    input  logic        Zlow_out,
    input  logic        HI_out,
    input  logic        LO_out,
    input  logic        MDR_out,
    input  logic        InPort_out,
    input  logic        C_out,
    input  logic        IncPC,
    input  logic        Read,
    input  logic        Write,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin,
    input  logic        Rout,
    input  logic        BAout,
    input  logic [4:0]  alu_instruction_bits,
    input  logic [31:0] InPort_Data_In,
    output logic        CON_out,
    output logic [31:0] Bus_Data,
    output logic [31:0] ALUHigh_Data,
    output logic [31:0] ALULow_Data,
    output logic [31:0] R0_Data,
    output logic [31:0] R1_Data,
    output logic [31:0] R2_Data,
    output logic [31:0] R3_Data,
    output logic [31:0] R4_Data,
    output logic [31:0] R5_Data,
    output logic [31:0] R6_Data,
    output logic [31:0] R7_Data,
    output logic [31:0] R8_Data,
    output logic [31:0] R9_Data,
    output logic [31:0] R10_Data,
    output logic [31:0] R11_Data,
    output logic [31:0] R12_Data,
    output logic [31:0] R13_Data,
    output logic [31:0] R14_Data,
    output logic [31:0] R15_Data,
    output logic [31:0] PC_Data,
    output logic [31:0] IR_Data,
    output logic [31:0] Y_Data,
    output logic [31:0] Zhigh_Data,
    output logic [31:0] Zlow_Data,
    output logic [31:0] HI_Data,
    output logic [31:0] LO_Data,
    output logic [31:0] MAR_Data,
    output logic [31:0] MDR_Data,
    output logic [31:0] InPort_Data,
    output logic [31:0] OutPort_Data,
    output logic [31:0] C_sign_extended_Data,
    output logic [31:0] Mdatain
);

    logic [31:0] r [16];
    logic [31:0] pc, ir, y, zhi, zlo, hi, lo, mar, mdr, inp, outp;
    logic        con;
    logic [3:0]  sel;
    logic [15:0] dec;
    logic [31:0] bus;
    logic [63:0] alu_res;
    logic [31:0] mdr_d;
    logic        con_d;
    logic [31:0] ram [RAM_DEPTH];

    always_comb begin
        sel = 4'd0;
        if (Gra)      sel = ir[RA_HI:RA_LO];
        else if (Grb) sel = ir[RB_HI:RB_LO];
        else if (Grc) sel = ir[RC_HI:RC_LO];
    end

    assign dec    = 16'h0001 << sel;
    assign RX_in  = RX_in_man | (Rin ? dec : 16'h0000);
    assign RX_out = RX_out_man | ((Rout | BAout) ? dec : 16'h0000);

    assign C_sign_extended_Data = sext19(ir[CK_HI:0]);

    // Lowest-priority sources are applied first so later
    // assignments win; R0 ends up with the highest priority.
    always_comb begin
        bus = '0;
        if (C_out)      bus = C_sign_extended_Data;
        if (InPort_out) bus = inp;
        if (MDR_out)    bus = mdr;
        if (PC_out)     bus = pc;
        if (Zlow_out)   bus = zlo;
        if (Zhigh_out)  bus = zhi;
        if (LO_out)     bus = lo;
        if (HI_out)     bus = hi;
        for (int i = 15; i >= 0; i--) begin
            if (RX_out[i]) bus = r[i];
        end
        // Base-address R0 reads as zero.
        if (RX_out[0] && BAout) bus = '0;
    end

    datapath_alu u_alu (
        .a      (y),
        .b      (bus),
        .op     (alu_instruction_bits),
        .inc_pc (IncPC),
        .result (alu_res)
    );

    always_comb begin
        con_d = 1'b0;
        case (ir[C2_HI:C2_LO])
            2'b00: con_d = (bus == 32'd0);
            2'b01: con_d = (bus != 32'd0);
            2'b10: con_d = ~bus[31];
            2'b11: con_d = bus[31];
            default: con_d = 1'b0;
        endcase
    end

    assign mdr_d   = Read ? Mdatain : bus;
    assign Mdatain = ram[mar[RAM_AW-1:0]];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) r[i] <= '0;
            pc   <= '0;
            ir   <= '0;
            y    <= '0;
            zhi  <= '0;
            zlo  <= '0;
            hi   <= '0;
            lo   <= '0;
            mar  <= '0;
            mdr  <= '0;
            inp  <= '0;
            outp <= '0;
            con  <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (RX_in[i]) r[i] <= bus;
            end
            if (PC_in)      pc   <= bus;
            if (IR_in)      ir   <= bus;
            if (Y_in)       y    <= bus;
            if (Z_in)       zhi  <= alu_res[63:32];
            if (Z_in)       zlo  <= alu_res[31:0];
            if (HI_in)      hi   <= bus;
            if (LO_in)      lo   <= bus;
            if (MAR_in)     mar  <= bus;
            if (MDR_in)     mdr  <= mdr_d;
            if (OutPort_in) outp <= bus;
            inp <= InPort_Data_In;
            if (Gra && Rout) con <= con_d;
        end
    end

    // Store what MDR will hold after this edge, so a
    // load-and-write in one step stores the new value.
    always_ff @(posedge clk) begin
        if (Write) ram[mar[RAM_AW-1:0]] <= MDR_in ? mdr_d : mdr;
    end

    assign R0_Data  = r[0];
    assign R1_Data  = r[1];
    assign R2_Data  = r[2];
    assign R3_Data  = r[3];
    assign R4_Data  = r[4];
    assign R5_Data  = r[5];
    assign R6_Data  = r[6];
    assign R7_Data  = r[7];
    assign R8_Data  = r[8];
    assign R9_Data  = r[9];
    assign R10_Data = r[10];
    assign R11_Data = r[11];
    assign R12_Data = r[12];
    assign R13_Data = r[13];
    assign R14_Data = r[14];
    assign R15_Data = r[15];

    assign Bus_Data     = bus;
    assign ALUHigh_Data = alu_res[63:32];
    assign ALULow_Data  = alu_res[31:0];
    assign PC_Data      = pc;
    assign IR_Data      = ir;
    assign Y_Data       = y;
    assign Zhigh_Data   = zhi;
    assign Zlow_Data    = zlo;
    assign HI_Data      = hi;
    assign LO_Data      = lo;
    assign MAR_Data     = mar;
    assign MDR_Data     = mdr;
    assign InPort_Data  = inp;
    assign OutPort_Data = outp;
    assign CON_out      = con;

endmodule

// File: tb/tb_mini_src_datapath.sv
// Directed bench for mini_src_datapath: reset, register loads,
// fetch, store/load sequences, CON flag and ALU ops.
module tb_mini_src_datapath;
    import mini_src_pkg::*;

    logic        clk;
    logic        clr;
    logic [15:0] RX_in_man, RX_out_man, RX_in, RX_out;
    logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in;
    logic OutPort_in, PC_out, Zhigh_out, Zlow_out, HI_out, LO_out;
    logic MDR_out, InPort_out, C_out, IncPC, Read, Write;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0]  alu_instruction_bits;
    logic [31:0] InPort_Data_In;
    logic        CON_out;
    logic [31:0] Bus_Data, ALUHigh_Data, ALULow_Data;
    logic [31:0] R0_Data, R1_Data, R2_Data, R3_Data;
    logic [31:0] R4_Data, R5_Data, R6_Data, R7_Data;
    logic [31:0] R8_Data, R9_Data, R10_Data, R11_Data;
    logic [31:0] R12_Data, R13_Data, R14_Data, R15_Data;
    logic [31:0] PC_Data, IR_Data, Y_Data, Zhigh_Data, Zlow_Data;
    logic [31:0] HI_Data, LO_Data, MAR_Data, MDR_Data;
    logic [31:0] InPort_Data, OutPort_Data;
    logic [31:0] C_sign_extended_Data, Mdatain;

    int total = 0;
    int bad   = 0;

    mini_src_datapath dut (
        .clk(clk), .clr(clr),
        .RX_in_man(RX_in_man), .RX_out_man(RX_out_man),
        .RX_in(RX_in), .RX_out(RX_out),
        .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in),
        .HI_in(HI_in), .LO_in(LO_in), .MAR_in(MAR_in),
        .MDR_in(MDR_in), .OutPort_in(OutPort_in),
        .PC_out(PC_out), .Zhigh_out(Zhigh_out),
        .Zlow_out(Zlow_out), .HI_out(HI_out), .LO_out(LO_out),
        .MDR_out(MDR_out), .InPort_out(InPort_out), .C_out(C_out),
        .IncPC(IncPC), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout),
        .alu_instruction_bits(alu_instruction_bits),
        .InPort_Data_In(InPort_Data_In), .CON_out(CON_out),
        .Bus_Data(Bus_Data), .ALUHigh_Data(ALUHigh_Data),
        .ALULow_Data(ALULow_Data),
        .R0_Data(R0_Data), .R1_Data(R1_Data), .R2_Data(R2_Data),
        .R3_Data(R3_Data), .R4_Data(R4_Data), .R5_Data(R5_Data),
        .R6_Data(R6_Data), .R7_Data(R7_Data), .R8_Data(R8_Data),
        .R9_Data(R9_Data), .R10_Data(R10_Data),
        .R11_Data(R11_Data), .R12_Data(R12_Data),
        .R13_Data(R13_Data), .R14_Data(R14_Data),
        .R15_Data(R15_Data),
        .PC_Data(PC_Data), .IR_Data(IR_Data), .Y_Data(Y_Data),
        .Zhigh_Data(Zhigh_Data), .Zlow_Data(Zlow_Data),
        .HI_Data(HI_Data), .LO_Data(LO_Data),
        .MAR_Data(MAR_Data), .MDR_Data(MDR_Data),
        .InPort_Data(InPort_Data), .OutPort_Data(OutPort_Data),
        .C_sign_extended_Data(C_sign_extended_Data),
        .Mdatain(Mdatain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctl();
        RX_in_man = '0; RX_out_man = '0;
        PC_in = 0; IR_in = 0; Y_in = 0; Z_in = 0; HI_in = 0;
        LO_in = 0; MAR_in = 0; MDR_in = 0; OutPort_in = 0;
        PC_out = 0; Zhigh_out = 0; Zlow_out = 0; HI_out = 0;
        LO_out = 0; MDR_out = 0; InPort_out = 0; C_out = 0;
        IncPC = 0; Read = 0; Write = 0;
        Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
        alu_instruction_bits = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_ctl();
    endtask

    task automatic ram_write(input logic [31:0] a,
                             input logic [31:0] v);
        InPort_Data_In = a; step();
        InPort_out = 1; MAR_in = 1; step();
        InPort_Data_In = v; step();
        InPort_out = 1; MDR_in = 1; Write = 1; step();
    endtask

    task automatic fetch();
        PC_out = 1; MAR_in = 1; IncPC = 1; Z_in = 1; step();
        Zlow_out = 1; PC_in = 1; Read = 1; MDR_in = 1; step();
        MDR_out = 1; IR_in = 1; step();
    endtask

    task automatic set_y(input logic [31:0] v);
        InPort_Data_In = v; step();
        InPort_out = 1; Y_in = 1; step();
    endtask

    task automatic alu(input logic [4:0] op, input logic [31:0] b);
        InPort_Data_In = b; step();
        InPort_out = 1; alu_instruction_bits = op; Z_in = 1; step();
    endtask

    task automatic load_ir(input logic [31:0] v);
        InPort_Data_In = v; step();
        InPort_out = 1; IR_in = 1; step();
    endtask

    initial begin
        clear_ctl();
        clr = 0;
        InPort_Data_In = '0;
        #2;

        // Dirty some registers, then reset.
        InPort_Data_In = 32'hABCD; step();
        InPort_out = 1; PC_in = 1; RX_in_man = 16'h0010; step();
        clr = 1; step(); clr = 0;
        chk("rst_pc", PC_Data, 32'h0);
        chk("rst_r4", R4_Data, 32'h0);
        chk("rst_inport", InPort_Data, 32'h0);
        chk("rst_bus", Bus_Data, 32'h0);
        chk("rst_z", Zlow_Data, 32'h0);

        // Load R4 from the input port.
        InPort_Data_In = 32'h67;
        InPort_out = 1; RX_in_man = 16'h0010; step();
        InPort_out = 1; RX_in_man = 16'h0010; step();
        chk("ld_r4", R4_Data, 32'h67);

        ram_write(32'h0, 32'h12200090);
        chk("mdr_wr", MDR_Data, 32'h12200090);
        ram_write(32'h1, 32'h000000F7);
        chk("ram1", Mdatain, 32'h000000F7);

        InPort_Data_In = 32'h55;
        InPort_out = 1; RX_in_man = 16'h0001; step();
        InPort_out = 1; RX_in_man = 16'h0001; step();
        chk("ld_r0", R0_Data, 32'h55);

        // st 0x90(R4), R4
        fetch();
        chk("st_pc", PC_Data, 32'h1);
        chk("st_ir", IR_Data, 32'h12200090);
        chk("st_c", C_sign_extended_Data, 32'h90);
        Grb = 1; BAout = 1; Y_in = 1; step();
        chk("st_y", Y_Data, 32'h67);
        C_out = 1; alu_instruction_bits = OP_ADD; Z_in = 1; step();
        Zlow_out = 1; MAR_in = 1; step();
        chk("st_mar", MAR_Data, 32'hF7);
        Gra = 1; Rout = 1; MDR_in = 1; Write = 1; step();
        chk("st_mdr", MDR_Data, 32'h67);
        chk("st_ram", Mdatain, 32'h67);

        // ld R0, 0xF7(R0): base R0 reads as zero
        fetch();
        chk("ld_pc", PC_Data, 32'h2);
        chk("ld_ir", IR_Data, 32'hF7);
        Grb = 1; BAout = 1; Y_in = 1; step();
        chk("ld_y", Y_Data, 32'h0);
        C_out = 1; alu_instruction_bits = OP_ADD; Z_in = 1; step();
        Zlow_out = 1; MAR_in = 1; step();
        chk("ld_mar", MAR_Data, 32'hF7);
        Read = 1; MDR_in = 1; step();
        chk("ld_mdr", MDR_Data, 32'h67);
        MDR_out = 1; Gra = 1; Rin = 1; step();
        chk("ld_r0_res", R0_Data, 32'h67);

        // CON: ra=R5 (zero), cond !=0 then ==0
        load_ir(32'h02880000);
        Gra = 1; Rout = 1; #1;
        chk("rx_out", {16'h0, RX_out}, 32'h0020);
        step();
        chk("con_ne", {31'h0, CON_out}, 32'h0);
        load_ir(32'h02800000);
        Gra = 1; Rout = 1; step();
        chk("con_eq", {31'h0, CON_out}, 32'h1);

        set_y(32'hFFFFFFFE);
        alu(OP_MUL, 32'h3);
        chk("mul_hi", Zhigh_Data, 32'hFFFFFFFF);
        chk("mul_lo", Zlow_Data, 32'hFFFFFFFA);

        set_y(32'h7);
        alu(OP_DIV, 32'h2);
        chk("div_lo", Zlow_Data, 32'h3);
        chk("div_hi", Zhigh_Data, 32'h1);
        alu(OP_DIV, 32'h0);
        chk("div0_lo", Zlow_Data, 32'h0);
        chk("div0_hi", Zhigh_Data, 32'h0);

        set_y(32'h80000001);
        alu(OP_ROR, 32'h1);
        chk("ror", Zlow_Data, 32'hC0000000);
        alu(OP_ROL, 32'h1);
        chk("rol", Zlow_Data, 32'h00000003);
        alu(OP_SHRA, 32'h4);
        chk("shra", Zlow_Data, 32'hF8000000);
        alu(OP_SHR, 32'h4);
        chk("shr", Zlow_Data, 32'h08000000);

        set_y(32'h5);
        alu(OP_SUB, 32'h7);
        chk("sub", Zlow_Data, 32'hFFFFFFFE);
        alu(OP_NEG, 32'h1);
        chk("neg", Zlow_Data, 32'hFFFFFFFF);
        alu(OP_NOT, 32'h0000FFFF);
        chk("not", Zlow_Data, 32'hFFFF0000);
        alu(OP_AND, 32'h6);
        chk("and", Zlow_Data, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
